// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg
//   Shared types and width helpers for the UART transmitter arbiter.
//   arb_state_t  : arbiter FSM state encoding
//   idx_width()  : bits needed to index NUM_REQ requesters (at least 1)
//   timer_width(): bits for a timer that must reach max(START_TIMEOUT, GAP_CYCLES)
package uart_arb_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_DONE = 2'd2,
    GAP       = 2'd3
  } arb_state_t;

  localparam int unsigned FRAME_CNT_W = 16;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned timer_width(input int unsigned start_timeout,
                                              input int unsigned gap_cycles);
    int unsigned m;
    int unsigned w;
    m = (start_timeout > gap_cycles) ? start_timeout : gap_cycles;
    w = $clog2(m + 1);
    return (w > 0) ? w : 1;
  endfunction

  // Widths for the default configuration (4 requesters, 1024/16 cycle timers).
  localparam int unsigned DEFAULT_IDX_W = idx_width(4);
  localparam int unsigned DEFAULT_TMR_W = timer_width(1024, 16);

endpackage

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// rr_arbiter
//   Combinational round-robin pick: returns the first set bit of `eligible`
//   at or after index `ptr`, wrapping modulo NUM_REQ.
//   eligible    in  NUM_REQ  requesters allowed to win this cycle
//   ptr         in  IDX_W    highest-priority index
//   grant_valid out 1        at least one requester is eligible
//   grant_idx   out IDX_W    winning index (0 when grant_valid is 0)
module rr_arbiter
  import uart_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] eligible,
  input  logic [IDX_W-1:0]   ptr,
  output logic               grant_valid,
  output logic [IDX_W-1:0]   grant_idx
);

  logic [NUM_REQ-1:0] rot;
  logic [IDX_W:0]     sum;

  always_comb begin
    // Rotate so that bit k of `rot` is requester (ptr + k) mod NUM_REQ.
    rot         = NUM_REQ'({eligible, eligible} >> ptr);
    grant_valid = |rot;
    sum         = '0;
    // Scan from the far end so the lowest offset wins.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rot[k[IDX_W-1:0]]) begin
        sum = {1'b0, ptr} + k[IDX_W:0];
      end
    end
    if (sum >= (IDX_W + 1)'(NUM_REQ)) begin
      sum = sum - (IDX_W + 1)'(NUM_REQ);
    end
    grant_idx = sum[IDX_W-1:0];
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares one word-wide UART transmitter among NUM_REQ requesters with
//   round-robin fairness, a start/busy handshake, start timeout reporting
//   and a forced idle gap between frames. All outputs are registered.
//   clk          in  1               system clock
//   rst_n        in  1               synchronous active-low reset
//   req          in  NUM_REQ         level request per requester
//   req_mask     in  NUM_REQ         1 = requester enabled
//   req_data     in  NUM_REQ*DATA_W  packed words, requester i at [i*DATA_W +: DATA_W]
//   ack          out NUM_REQ         one-cycle pulse: word of requester i latched
//   tx_data      out DATA_W          latched word to the transmitter
//   tx_start     out 1               transmitter trigger
//   tx_busy      in  1               transmitter busy
//   tx_src       out IDX_W           current / most recent granted requester
//   arb_busy     out 1               FSM not in IDLE
//   err_timeout  out 1               one-cycle pulse when a start times out
//   frame_count  out 16              completed frames, wraps
//
// state     | meaning
// ----------+---------------------------------------------------------
// IDLE      | waiting for an eligible requester with the transmitter idle
// START     | tx_start high, waiting for tx_busy (bounded by START_TIMEOUT)
// WAIT_DONE | transmitter busy, waiting for it to finish the frame
// GAP       | forced idle gap before the next grant
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ       = 4,
  parameter int unsigned DATA_W        = 32,
  parameter int unsigned START_TIMEOUT = 1024,
  parameter int unsigned GAP_CYCLES    = 16,
  parameter int unsigned IDX_W         = idx_width(NUM_REQ),
  parameter int unsigned TMR_W         = timer_width(START_TIMEOUT, GAP_CYCLES)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_mask,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        ack,
  output logic [DATA_W-1:0]         tx_data,
  output logic                      tx_start,
  input  logic                      tx_busy,
  output logic [IDX_W-1:0]          tx_src,
  output logic                      arb_busy,
  output logic                      err_timeout,
  output logic [FRAME_CNT_W-1:0]    frame_count
);

  localparam logic [TMR_W-1:0] START_LAST = TMR_W'(START_TIMEOUT - 1);
  // With a zero gap the GAP state still lasts one cycle, so it exits at 0.
  localparam logic [TMR_W-1:0] GAP_LAST   =
    TMR_W'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);

  arb_state_t               state_q, state_d;
  logic [IDX_W-1:0]         ptr_q, ptr_d;
  logic [TMR_W-1:0]         timer_q, timer_d;
  logic [DATA_W-1:0]        tx_data_q, tx_data_d;
  logic [IDX_W-1:0]         tx_src_q, tx_src_d;
  logic [NUM_REQ-1:0]       ack_q, ack_d;
  logic                     tx_start_q, tx_start_d;
  logic                     arb_busy_q, arb_busy_d;
  logic                     err_timeout_q, err_timeout_d;
  logic [FRAME_CNT_W-1:0]   frame_count_q, frame_count_d;

  logic [NUM_REQ-1:0]       eligible;
  logic                     grant_valid;
  logic [IDX_W-1:0]         grant_idx;
  logic [DATA_W-1:0]        grant_word;

  assign eligible = req & req_mask;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_arbiter (
    .eligible    (eligible),
    .ptr         (ptr_q),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  always_comb begin
    grant_word = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == IDX_W'(i)) begin
        grant_word = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    timer_d       = timer_q;
    tx_data_d     = tx_data_q;
    tx_src_d      = tx_src_q;
    ack_d         = '0;
    err_timeout_d = 1'b0;
    frame_count_d = frame_count_q;

    unique case (state_q)
      IDLE: begin
        // A transmitter already busy from another user blocks the grant.
        if (grant_valid && !tx_busy) begin
          tx_data_d = grant_word;
          tx_src_d  = grant_idx;
          ack_d     = NUM_REQ'(1) << grant_idx;
          ptr_d     = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
          timer_d   = '0;
          state_d   = START;
        end
      end
      START: begin
        // Busy takes priority over an expiring timer.
        if (tx_busy) begin
          state_d = WAIT_DONE;
        end else if (timer_q == START_LAST) begin
          err_timeout_d = 1'b1;
          timer_d       = '0;
          state_d       = GAP;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          frame_count_d = frame_count_q + 1'b1;
          timer_d       = '0;
          state_d       = GAP;
        end
      end
      GAP: begin
        if (timer_q == GAP_LAST) begin
          state_d = IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Registered copies of the next state keep the outputs glitch-free.
    tx_start_d = (state_d == START);
    arb_busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      ptr_q         <= '0;
      timer_q       <= '0;
      tx_data_q     <= '0;
      tx_src_q      <= '0;
      ack_q         <= '0;
      tx_start_q    <= 1'b0;
      arb_busy_q    <= 1'b0;
      err_timeout_q <= 1'b0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      timer_q       <= timer_d;
      tx_data_q     <= tx_data_d;
      tx_src_q      <= tx_src_d;
      ack_q         <= ack_d;
      tx_start_q    <= tx_start_d;
      arb_busy_q    <= arb_busy_d;
      err_timeout_q <= err_timeout_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign ack         = ack_q;
  assign tx_data     = tx_data_q;
  assign tx_start    = tx_start_q;
  assign tx_src      = tx_src_q;
  assign arb_busy    = arb_busy_q;
  assign err_timeout = err_timeout_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;

  localparam int TO  = 40;
  localparam int GAP = 5;
  localparam int START_SEEN = 4;

  logic         clk;
  logic         rst_n;
  logic [3:0]   req;
  logic [3:0]   req_mask;
  logic [127:0] req_data;
  logic [3:0]   ack;
  logic [31:0]  tx_data;
  logic         tx_start;
  logic         tx_busy;
  logic [1:0]   tx_src;
  logic         arb_busy;
  logic         err_timeout;
  logic [15:0]  frame_count;

  uart_tx_arbiter #(
    .NUM_REQ       (4),
    .DATA_W        (32),
    .START_TIMEOUT (TO),
    .GAP_CYCLES    (GAP)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .req_mask    (req_mask),
    .req_data    (req_data),
    .ack         (ack),
    .tx_data     (tx_data),
    .tx_start    (tx_start),
    .tx_busy     (tx_busy),
    .tx_src      (tx_src),
    .arb_busy    (arb_busy),
    .err_timeout (err_timeout),
    .frame_count (frame_count)
  );

  typedef struct {
    int          idx;
    logic [31:0] data;
  } exp_t;

  typedef struct {
    logic [3:0] req;
    logic [3:0] mask;
    int         exp_idx;
  } vec_t;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int ack_cnt = 0;
  int err_cnt = 0;
  int err_cyc = 0;
  int start_run = 0;
  int last_start_len = 0;
  logic [3:0] odd_ack = 4'b0;
  exp_t sb[$];
  int grant_cyc[$];
  logic [31:0] words[4];

  int  busy_len = 6;
  bit  stuck = 0;
  bit  ext_busy = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic expect_grant(input int idx);
    exp_t e;
    e.idx  = idx;
    e.data = words[idx];
    sb.push_back(e);
  endtask

  task automatic wait_acks(input int target, input int budget, input string name);
    int i;
    i = 0;
    while (ack_cnt < target && i < budget) begin
      tick(1);
      i++;
    end
    chk(name, 64'(ack_cnt >= target), 64'd1);
  endtask

  task automatic wait_idle(input int budget, input string name);
    int i;
    i = 0;
    while (arb_busy && i < budget) begin
      tick(1);
      i++;
    end
    chk(name, 64'(arb_busy), 64'd0);
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    sb.delete();
    tick(1);
  endtask

  // Transmitter model: busy rises once tx_start has been seen for START_SEEN
  // samples, then stays high for busy_len cycles.
  initial begin
    int m_cnt;
    int m_phase;
    logic m_busy;
    m_cnt = 0;
    m_phase = 0;
    m_busy = 1'b0;
    tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_busy = 1'b0;
        m_cnt = 0;
        m_phase = 0;
      end else if (m_phase == 0) begin
        if (tx_start && !stuck) begin
          m_cnt++;
          if (m_cnt == START_SEEN) begin
            m_busy = 1'b1;
            m_cnt = 0;
            m_phase = 1;
          end
        end else begin
          m_cnt = 0;
        end
      end else begin
        m_cnt++;
        if (m_cnt == busy_len) begin
          m_busy = 1'b0;
          m_cnt = 0;
          m_phase = 0;
        end
      end
      tx_busy = m_busy | ext_busy;
    end
  end

  // Monitor: scoreboard pop on every ack, tx_start run length, error pulses.
  initial begin
    exp_t e;
    logic [3:0] exp_ack;
    forever begin
      @(negedge clk);
      if (ack !== 4'b0) begin
        ack_cnt++;
        grant_cyc.push_back(cyc);
        odd_ack = odd_ack | (ack & 4'b1010);
        if (sb.size() == 0) begin
          chk("unexpected_ack", 64'(ack), 64'd0);
        end else begin
          e = sb.pop_front();
          exp_ack = 4'b0001 << e.idx;
          chk("ack_vector", 64'(ack), 64'(exp_ack));
          chk("tx_src", 64'(tx_src), 64'(e.idx));
          chk("tx_data", 64'(tx_data), 64'(e.data));
          chk("tx_start_with_ack", 64'(tx_start), 64'd1);
        end
      end
      if (tx_start) begin
        start_run++;
      end else if (start_run > 0) begin
        last_start_len = start_run;
        start_run = 0;
      end
      if (err_timeout) begin
        if (err_cnt == 0) err_cyc = cyc;
        err_cnt++;
      end
    end
  end

  initial begin
    vec_t vecs[10];
    int base;
    int fc0;
    int t0;
    int i;

    vecs[0] = '{4'b0001, 4'b1111, 0};
    vecs[1] = '{4'b0001, 4'b1111, 0};
    vecs[2] = '{4'b1001, 4'b1111, 3};
    vecs[3] = '{4'b1001, 4'b1111, 0};
    vecs[4] = '{4'b1100, 4'b0100, 2};
    vecs[5] = '{4'b0111, 4'b1111, 0};
    vecs[6] = '{4'b1110, 4'b1011, 1};
    vecs[7] = '{4'b1111, 4'b0001, 0};
    vecs[8] = '{4'b0101, 4'b1111, 2};
    vecs[9] = '{4'b1111, 4'b1111, 3};

    words[0] = 32'hDEADBEEF;
    words[1] = 32'h12345678;
    words[2] = 32'hA5A50F0F;
    words[3] = 32'h0BADF00D;
    req_data = {words[3], words[2], words[1], words[0]};
    req = 4'b0;
    req_mask = 4'b1111;
    rst_n = 1'b0;
    tick(3);

    // Reset values
    chk("rst_ack", 64'(ack), 64'd0);
    chk("rst_tx_data", 64'(tx_data), 64'd0);
    chk("rst_tx_start", 64'(tx_start), 64'd0);
    chk("rst_tx_src", 64'(tx_src), 64'd0);
    chk("rst_arb_busy", 64'(arb_busy), 64'd0);
    chk("rst_err", 64'(err_timeout), 64'd0);
    chk("rst_frames", 64'(frame_count), 64'd0);
    rst_n = 1'b1;
    tick(2);

    // Single requester, 100-cycle frame
    busy_len = 100;
    req = 4'b0001;
    expect_grant(0);
    wait_acks(1, 20, "single_ack_seen");
    req = 4'b0;
    wait_idle(300, "single_idle");
    chk("single_start_len", 64'(last_start_len), 64'd4);
    chk("single_frames", 64'(frame_count), 64'd1);
    chk("single_ack_count", 64'(ack_cnt), 64'd1);
    chk("single_data_stable", 64'(tx_data), 64'hDEADBEEF);

    // Table of single grants from pointer 0
    reset_dut();
    busy_len = 6;
    fc0 = int'(frame_count);
    for (int v = 0; v < 10; v++) begin
      req = vecs[v].req;
      req_mask = vecs[v].mask;
      expect_grant(vecs[v].exp_idx);
      base = ack_cnt;
      wait_acks(base + 1, 60, "tbl_ack_seen");
      chk("tbl_src", 64'(tx_src), 64'(vecs[v].exp_idx));
      req = 4'b0;
      wait_idle(100, "tbl_idle");
      chk("tbl_frames", 64'(frame_count), 64'(fc0 + v + 1));
    end

    // Fairness: all held, pointer at 0
    busy_len = 10;
    req = 4'b1111;
    req_mask = 4'b1111;
    grant_cyc.delete();
    base = ack_cnt;
    expect_grant(0);
    expect_grant(1);
    expect_grant(2);
    expect_grant(3);
    expect_grant(0);
    wait_acks(base + 5, 200, "fair_acks_seen");
    req = 4'b0;
    wait_idle(100, "fair_idle");
    for (int k = 1; k < grant_cyc.size() && k < 5; k++) begin
      chk("fair_spacing", 64'(grant_cyc[k] - grant_cyc[k-1]), 64'(START_SEEN + 10 + GAP + 1));
    end

    // Masking 0101, then mask everything off mid-frame
    reset_dut();
    busy_len = 6;
    odd_ack = 4'b0;
    req = 4'b1111;
    req_mask = 4'b0101;
    base = ack_cnt;
    expect_grant(0);
    expect_grant(2);
    expect_grant(0);
    expect_grant(2);
    wait_acks(base + 4, 200, "mask_acks_seen");
    req_mask = 4'b0000;
    wait_idle(100, "mask_idle");
    tick(20);
    chk("mask_frames", 64'(frame_count), 64'd4);
    chk("mask_ack_count", 64'(ack_cnt - base), 64'd4);
    chk("mask_odd_acks", 64'(odd_ack), 64'd0);
    req = 4'b0;
    req_mask = 4'b1111;

    // Timeout with busy stuck low; requester 0 appears and leaves meanwhile
    fc0 = int'(frame_count);
    stuck = 1'b1;
    req = 4'b0100;
    grant_cyc.delete();
    base = ack_cnt;
    expect_grant(2);
    wait_acks(base + 1, 20, "to_ack_seen");
    t0 = (grant_cyc.size() > 0) ? grant_cyc[0] : 0;
    req = 4'b0101;
    i = 0;
    while (err_cnt == 0 && i < 100) begin
      tick(1);
      i++;
    end
    chk("to_err_seen", 64'(err_cnt), 64'd1);
    chk("to_err_latency", 64'(err_cyc - t0), 64'(TO));
    chk("to_frames_unchanged", 64'(frame_count), 64'(fc0));
    stuck = 1'b0;
    req = 4'b0100;
    expect_grant(2);
    wait_acks(base + 2, 40, "to_regrant_seen");
    if (grant_cyc.size() >= 2) begin
      chk("to_regrant_spacing", 64'(grant_cyc[1] - grant_cyc[0]), 64'(TO + GAP + 1));
    end
    req = 4'b0;
    wait_idle(100, "to_idle");
    chk("to_frames_after", 64'(frame_count), 64'(fc0 + 1));
    chk("to_err_total", 64'(err_cnt), 64'd1);

    // Reset in WAIT_DONE, then grants resume from index 0
    busy_len = 30;
    req = 4'b0010;
    base = ack_cnt;
    expect_grant(1);
    wait_acks(base + 1, 20, "rm_ack_seen");
    req = 4'b0;
    i = 0;
    while (!(tx_busy && !tx_start && arb_busy) && i < 50) begin
      tick(1);
      i++;
    end
    chk("rm_in_wait_done", 64'(tx_busy && !tx_start && arb_busy), 64'd1);
    tick(3);
    rst_n = 1'b0;
    tick(1);
    chk("rm_ack", 64'(ack), 64'd0);
    chk("rm_tx_data", 64'(tx_data), 64'd0);
    chk("rm_tx_start", 64'(tx_start), 64'd0);
    chk("rm_tx_src", 64'(tx_src), 64'd0);
    chk("rm_arb_busy", 64'(arb_busy), 64'd0);
    chk("rm_err", 64'(err_timeout), 64'd0);
    chk("rm_frames", 64'(frame_count), 64'd0);
    rst_n = 1'b1;
    sb.delete();
    busy_len = 6;
    tick(1);
    req = 4'b1111;
    base = ack_cnt;
    expect_grant(0);
    wait_acks(base + 1, 20, "rm_resume_seen");
    req = 4'b0;
    wait_idle(100, "rm_idle");

    // Transmitter busy from elsewhere, then frame counter wrap
    ext_busy = 1'b1;
    tick(2);
    req = 4'b0010;
    base = ack_cnt;
    tick(20);
    chk("pb_no_grant", 64'(ack_cnt - base), 64'd0);
    chk("pb_arb_idle", 64'(arb_busy), 64'd0);
    force dut.frame_count_q = 16'hFFFF;
    tick(1);
    release dut.frame_count_q;
    tick(1);
    chk("pb_preload", 64'(frame_count), 64'hFFFF);
    expect_grant(1);
    ext_busy = 1'b0;
    wait_acks(base + 1, 20, "pb_ack_seen");
    req = 4'b0;
    wait_idle(100, "pb_idle");
    chk("pb_wrap", 64'(frame_count), 64'd0);
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
